// File: rtl/complex_divider.sv
// complex_divider
// Computes the complex quotient q = a / b of two 16+16 bit signed operands
// using a multi-cycle restoring divider that works on the real and imaginary
// parts in parallel. Each quotient part is truncated toward zero and
// saturated to the signed 16-bit range.
//
// Ports
//   clk           : rising-edge system clock
//   reset         : asynchronous, active-high reset
//   start         : operation request, only honoured while idle
//   comp_dividend : a, bits 31:16 real, 15:0 imaginary (signed)
//   comp_divisor  : b, same packing as comp_dividend
//   comp_quotient : registered result, same packing, held until next done
//   busy          : high while an operation is in flight
//   done          : one-cycle pulse when comp_quotient is updated
//   div_by_zero   : last completed operation had divisor 0+0i
//   saturated     : last completed operation clamped at least one part
module complex_divider (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] comp_dividend,
  input  logic [31:0] comp_divisor,
  output logic [31:0] comp_quotient,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic        saturated
);

  typedef enum logic [1:0] {IDLE, PREP, DIV, FIX} state_t;

  state_t      state_q, state_d;
  logic [31:0] dividend_q, dividend_d;
  logic [31:0] divisor_q, divisor_d;
  logic        signRe_q, signRe_d, signIm_q, signIm_d;
  logic [32:0] remRe_q, remRe_d, remIm_q, remIm_d;
  logic [31:0] quoRe_q, quoRe_d, quoIm_q, quoIm_d;
  logic [31:0] den_q, den_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] quotient_q, quotient_d;
  logic        done_q, done_d;
  logic        divByZero_q, divByZero_d;
  logic        saturated_q, saturated_d;

  // One restoring shift-subtract step: the quotient register starts out
  // holding the dividend magnitude and is shifted into the remainder one
  // bit per step while quotient bits are shifted in from the right.
  function automatic logic [64:0] divStep(input logic [32:0] rem,
                                          input logic [31:0] quo,
                                          input logic [31:0] den);
    logic [32:0] shifted;
    shifted = {rem[31:0], quo[31]};
    if (shifted >= {1'b0, den})
      return {shifted - {1'b0, den}, quo[30:0], 1'b1};
    return {shifted, quo[30:0], 1'b0};
  endfunction

  // Re-applies the sign to an unsigned quotient magnitude and clamps it to
  // the signed 16-bit range; the top bit of the result flags a clamp.
  function automatic logic [16:0] applySign(input logic neg, input logic [31:0] mag);
    logic [31:0] negMag;
    negMag = ~mag + 32'd1;
    if (!neg) begin
      if (mag > 32'd32767) return {1'b1, 16'h7FFF};
      return {1'b0, mag[15:0]};
    end
    if (mag > 32'd32768) return {1'b1, 16'h8000};
    return {1'b0, negMag[15:0]};
  endfunction

  logic signed [15:0] ar, ai, br, bi;
  logic signed [31:0] pArBr, pAiBi, pAiBr, pArBi, pBrBr, pBiBi;
  logic signed [32:0] nr, ni;
  logic [31:0]        denPrep, magRe, magIm;
  logic [64:0]        stepRe, stepIm;
  logic [16:0]        fixRe, fixIm;

  assign ar = dividend_q[31:16];
  assign ai = dividend_q[15:0];
  assign br = divisor_q[31:16];
  assign bi = divisor_q[15:0];

  assign pArBr = 32'(ar) * 32'(br);
  assign pAiBi = 32'(ai) * 32'(bi);
  assign pAiBr = 32'(ai) * 32'(br);
  assign pArBi = 32'(ar) * 32'(bi);
  assign pBrBr = 32'(br) * 32'(br);
  assign pBiBi = 32'(bi) * 32'(bi);

  // Numerators need 33 bits: the sum of two full-scale products reaches 2^31.
  assign nr = 33'(pArBr) + 33'(pAiBi);
  assign ni = 33'(pAiBr) - 33'(pArBi);

  // Both squares are non-negative, so the denominator is summed unsigned.
  assign denPrep = $unsigned(pBrBr) + $unsigned(pBiBi);

  // The magnitude of a 33-bit numerator never exceeds 2^31, so the low 32
  // bits of its two's complement negation are exact.
  assign magRe = nr[32] ? (~nr[31:0] + 32'd1) : nr[31:0];
  assign magIm = ni[32] ? (~ni[31:0] + 32'd1) : ni[31:0];

  assign stepRe = divStep(remRe_q, quoRe_q, den_q);
  assign stepIm = divStep(remIm_q, quoIm_q, den_q);
  assign fixRe  = applySign(signRe_q, quoRe_q);
  assign fixIm  = applySign(signIm_q, quoIm_q);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; a zero denominator skips the iterations entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = PREP;
      PREP:    state_d = (denPrep == 32'd0) ? FIX : DIV;
      DIV:     if (count_q == 5'd31) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    busy          = (state_q != IDLE);
    done          = done_q;
    comp_quotient = quotient_q;
    div_by_zero   = divByZero_q;
    saturated     = saturated_q;
  end

  // Datapath next-state: operands are only captured in IDLE, which keeps
  // them stable for the whole operation even if start stays high.
  always_comb begin
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    signRe_d    = signRe_q;
    signIm_d    = signIm_q;
    remRe_d     = remRe_q;
    remIm_d     = remIm_q;
    quoRe_d     = quoRe_q;
    quoIm_d     = quoIm_q;
    den_d       = den_q;
    count_d     = count_q;
    quotient_d  = quotient_q;
    divByZero_d = divByZero_q;
    saturated_d = saturated_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          dividend_d = comp_dividend;
          divisor_d  = comp_divisor;
        end
      end
      PREP: begin
        signRe_d = nr[32];
        signIm_d = ni[32];
        quoRe_d  = magRe;
        quoIm_d  = magIm;
        remRe_d  = '0;
        remIm_d  = '0;
        den_d    = denPrep;
        count_d  = '0;
      end
      DIV: begin
        {remRe_d, quoRe_d} = stepRe;
        {remIm_d, quoIm_d} = stepIm;
        count_d = count_q + 5'd1;
      end
      FIX: begin
        done_d = 1'b1;
        if (den_q == 32'd0) begin
          quotient_d  = '0;
          divByZero_d = 1'b1;
          saturated_d = 1'b0;
        end else begin
          quotient_d  = {fixRe[15:0], fixIm[15:0]};
          divByZero_d = 1'b0;
          saturated_d = fixRe[16] | fixIm[16];
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dividend_q  <= '0;
      divisor_q   <= '0;
      signRe_q    <= 1'b0;
      signIm_q    <= 1'b0;
      remRe_q     <= '0;
      remIm_q     <= '0;
      quoRe_q     <= '0;
      quoIm_q     <= '0;
      den_q       <= '0;
      count_q     <= '0;
      quotient_q  <= '0;
      done_q      <= 1'b0;
      divByZero_q <= 1'b0;
      saturated_q <= 1'b0;
    end else begin
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      signRe_q    <= signRe_d;
      signIm_q    <= signIm_d;
      remRe_q     <= remRe_d;
      remIm_q     <= remIm_d;
      quoRe_q     <= quoRe_d;
      quoIm_q     <= quoIm_d;
      den_q       <= den_d;
      count_q     <= count_d;
      quotient_q  <= quotient_d;
      done_q      <= done_d;
      divByZero_q <= divByZero_d;
      saturated_q <= saturated_d;
    end
  end

endmodule

// File: tb/tb_complex_divider.sv
// tb_complex_divider
// Scoreboard bench for complex_divider. Stimulus pushes the hand-computed
// result and the edge on which done must appear; a negedge monitor pops and
// compares every time the DUT pulses done.
module tb_complex_divider;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] comp_dividend = '0;
  logic [31:0] comp_divisor = '0;
  logic [31:0] comp_quotient;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic        saturated;

  complex_divider dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .comp_dividend(comp_dividend),
    .comp_divisor (comp_divisor),
    .comp_quotient(comp_quotient),
    .busy         (busy),
    .done         (done),
    .div_by_zero  (div_by_zero),
    .saturated    (saturated)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] quotient;
    logic        dbz;
    logic        sat;
    int          doneEdge;
  } expect_t;

  expect_t sbQueue[$];
  expect_t mon;
  int edgeCnt = 0;
  int vectorsApplied = 0;
  int miscompares = 0;
  int doneCount = 0;
  int doneSnapshot;

  // Rising-edge index, so latency can be checked against the start edge.
  always @(posedge clk) edgeCnt++;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    vectorsApplied++;
    if (actual !== required) begin
      miscompares++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, required);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      doneCount++;
      checkOutput("doneBusyExclusive", {31'd0, busy}, 32'd0);
      if (sbQueue.size() == 0) begin
        vectorsApplied++;
        miscompares++;
        $display("[TB] FAIL unexpectedDone: actual=done at edge %0d required=no done", edgeCnt);
      end else begin
        mon = sbQueue.pop_front();
        checkOutput({mon.name, ".quotient"}, comp_quotient, mon.quotient);
        checkOutput({mon.name, ".divByZero"}, {31'd0, div_by_zero}, {31'd0, mon.dbz});
        checkOutput({mon.name, ".saturated"}, {31'd0, saturated}, {31'd0, mon.sat});
        checkOutput({mon.name, ".doneEdge"}, edgeCnt, mon.doneEdge);
      end
    end
  end

  // Drives one request at the current negedge; the rising edge that samples
  // it is edgeCnt+1, and done follows 34 edges later (2 for a zero divisor).
  task automatic applyStimulus(input string name, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] expQ,
                               input logic expDbz, input logic expSat);
    expect_t e;
    comp_dividend = a;
    comp_divisor  = b;
    start         = 1'b1;
    e.name     = name;
    e.quotient = expQ;
    e.dbz      = expDbz;
    e.sat      = expSat;
    e.doneEdge = edgeCnt + 1 + ((b == 32'd0) ? 2 : 34);
    sbQueue.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns at the first negedge with busy low, i.e. in the done cycle.
  task automatic waitForIdle(input string name);
    int cycles;
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (busy !== 1'b0 && cycles < 100);
    if (busy !== 1'b0) begin
      vectorsApplied++;
      miscompares++;
      $display("[TB] FAIL %s.timeout: actual=busy after %0d cycles required=idle", name, cycles);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, ".quotient"}, comp_quotient, 32'd0);
    checkOutput({tag, ".busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, ".done"}, {31'd0, done}, 32'd0);
    checkOutput({tag, ".divByZero"}, {31'd0, div_by_zero}, 32'd0);
    checkOutput({tag, ".saturated"}, {31'd0, saturated}, 32'd0);
  endtask

  initial begin
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    checkResetOutputs("reset");
    reset = 1'b0;

    // Start on the first edge after reset release, then chain operations
    // back-to-back by issuing each one in the previous done cycle.
    applyStimulus("roundPos", 32'h0006_0008, 32'h0001_0002, 32'h0004_0000, 1'b0, 1'b0);
    waitForIdle("roundPos");
    applyStimulus("roundNeg", 32'h000A_FFFB, 32'h0000_0001, 32'hFFFB_FFF6, 1'b0, 1'b0);
    waitForIdle("roundNeg");
    applyStimulus("satReal", 32'h8000_0000, 32'hFFFF_0000, 32'h7FFF_0000, 1'b0, 1'b1);
    waitForIdle("satReal");
    applyStimulus("divZero", 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0);
    waitForIdle("divZero");
    applyStimulus("halfTrunc", 32'hFFF9_0007, 32'h0002_0000, 32'hFFFD_0003, 1'b0, 1'b0);
    waitForIdle("halfTrunc");
    applyStimulus("satBoth", 32'h7FFF_8000, 32'h0000_FFFF, 32'h7FFF_7FFF, 1'b0, 1'b1);
    waitForIdle("satBoth");
    applyStimulus("minBoundary", 32'h8000_8000, 32'h0001_FFFF, 32'h0000_8000, 1'b0, 1'b0);
    waitForIdle("minBoundary");
    applyStimulus("maxNoSat", 32'h7FFF_7FFF, 32'h0001_0000, 32'h7FFF_7FFF, 1'b0, 1'b0);
    waitForIdle("maxNoSat");

    // Start held high with changing operands while busy must be ignored.
    applyStimulus("protected", 32'h03E8_F830, 32'h0003_0004, 32'hFF38_FE70, 1'b0, 1'b0);
    for (int k = 0; k < 30; k++) begin
      start         = 1'b1;
      comp_dividend = $urandom;
      comp_divisor  = $urandom;
      @(negedge clk);
    end
    start = 1'b0;
    waitForIdle("protected");
    applyStimulus("backToBack", 32'h0064_0032, 32'h0007_FFFD, 32'h0009_000B, 1'b0, 1'b0);
    waitForIdle("backToBack");

    // Abort an operation part-way through the iterations.
    applyStimulus("aborted", 32'h0006_0008, 32'h0001_0002, 32'h0004_0000, 1'b0, 1'b0);
    repeat (11) @(negedge clk);
    reset = 1'b1;
    #1;
    void'(sbQueue.pop_back());
    checkResetOutputs("midReset");
    doneSnapshot = doneCount;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    checkOutput("noDoneAfterAbort", doneCount, doneSnapshot);

    applyStimulus("afterReset", 32'h000A_FFFB, 32'h0000_0001, 32'hFFFB_FFF6, 1'b0, 1'b0);
    waitForIdle("afterReset");
    repeat (10) @(negedge clk);
    checkOutput("scoreboardDrained", sbQueue.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule

// File: doc/complex_divider.md
COMPLEX_DIVIDER -- requirements
Module: complex_divider

Interface
REQ-001 SHALL declare ports in this order: clk  input  1  rising-edge system clock, the only clock.
REQ-002 SHALL provide reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL provide start  input  1  request; sampled only in IDLE.
REQ-004 SHALL provide comp_dividend  input  32  bits 31:16 real, 15:0 imag, each signed two's complement.
REQ-005 SHALL provide comp_divisor  input  32  same packing as comp_dividend.
REQ-006 SHALL provide comp_quotient  output  32  same packing; registered; holds its value until the next done.
REQ-007 SHALL provide busy  output  1  high while an operation is in flight.
REQ-008 SHALL provide done  output  1  one-cycle pulse when comp_quotient is updated.
REQ-009 SHALL provide div_by_zero  output  1  status of the last completed operation; divisor was 0+0i.
REQ-010 SHALL provide saturated  output  1  status of the last completed operation; at least one quotient part was clamped.

Function
REQ-011 SHALL compute q = a/b with a = dividend and b = divisor, as follows.
- nr = ar*br + ai*bi and ni = ai*br - ar*bi, each full precision, 33-bit signed.
- den = br*br + bi*bi, 32-bit unsigned.
REQ-012 SHALL produce each quotient part as its numerator divided by den, truncated toward zero.
REQ-013 SHALL clamp each part to [-32768, 32767]; saturated=1 if either part was clamped.
REQ-014 SHALL implement the FSM states IDLE, PREP, DIV, FIX.
REQ-015 SHALL, in IDLE with start=1 at edge N, latch both operands and enter PREP; busy=1 from that edge on.
REQ-016 SHALL, in PREP at edge N+1, perform the following.
- Register nr, ni and den.
- Register the numerator signs and the numerator magnitudes (32-bit unsigned).
- Clear the iteration counter and enter DIV.
REQ-017 SHALL, in DIV, run one restoring shift-subtract step per cycle on the real and imag magnitudes in parallel.
- The iterations occur at edges N+2 through N+33, 32 in total.
- DIV then enters FIX.
REQ-018 SHALL, in FIX at edge N+34, perform the following.
- Apply the signs, saturate, and write comp_quotient, div_by_zero=0 and saturated.
- Pulse done=1 and set busy=0, returning to IDLE.
- Latency: start-sampling edge to done = 34 cycles.
REQ-019 SHALL, in PREP with den==0, skip DIV and go to FIX.
- FIX then writes comp_quotient=0x0000_0000, div_by_zero=1 and saturated=0, with done at edge N+2.
REQ-020 SHALL ignore start while busy=1; latched operands SHALL NOT change mid-operation.
REQ-021 SHALL accept start in the cycle where done=1, since the state is IDLE, giving back-to-back operations with no idle cycle.
REQ-022 SHALL keep done low in every cycle except the single FIX-exit cycle.
REQ-023 SHALL give busy and done mutually exclusive values in every cycle.

Reset
REQ-024 SHALL, while reset=1, asynchronously force state=IDLE and the outputs below to 0:
- comp_quotient=0, busy=0, done=0, div_by_zero=0, saturated=0.
REQ-025 SHALL abort any in-flight operation on reset, with no done pulse afterwards.
REQ-026 SHALL sample start only at the first rising edge after reset deasserts.

Verification
REQ-027 SHALL check rounding toward zero.
- Stimulus: dividend=(6,8)=0x0006_0008, divisor=(1,2)=0x0001_0002.
- Response: done 34 cycles later, comp_quotient=0x0004_0000 (22/5 -> 4, -4/5 -> 0), saturated=0.
- Stimulus: dividend=(10,-5)=0x000A_FFFB, divisor=(0,1)=0x0000_0001.
- Response: comp_quotient=0xFFFB_FFF6 (-5,-10).
REQ-028 SHALL check saturation.
- Stimulus: dividend=0x8000_0000, divisor=0xFFFF_0000 (-1).
- Response: comp_quotient=0x7FFF_0000, saturated=1.
REQ-029 SHALL check division by zero.
- Stimulus: divisor=0x0000_0000, any dividend.
- Response: done at N+2, comp_quotient=0, div_by_zero=1, busy low after done.
REQ-030 SHALL check that operands are protected while busy.
- Stimulus: start held high and operands changed every cycle during busy.
- Response: a single done after 34 cycles, with the result of the first-latched operands.
- Stimulus: start=1 in the done cycle.
- Response: a second done exactly 34 cycles later.
REQ-031 SHALL check reset mid-operation.
- Stimulus: reset pulsed at cycle 10 of DIV.
- Response: all outputs 0 immediately, no done pulse.
- Stimulus: a new start after reset.
- Response: correct result at 34 cycles.
